// File: rtl/vr_pkg.sv
// Shared types and constants for the valid_ready source/sink pair.
package vr_pkg;
    typedef enum logic [1:0] {WAIT_DELAY, READY} sink_state_t;
    localparam int SEQ_START = 1;  // first value the source emits
endpackage

// File: rtl/valid_ready_if.sv
// Single-beat valid/ready bus between the data source and the sink.
interface valid_ready #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport Master (output data, output valid, input ready);
    modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/vr_delay_counter.sv
// Back-pressure delay counter; done once count+1 reaches delay (or delay is 0).
module vr_delay_counter #(
    parameter int DELAY_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DELAY_BITS-1:0] delay,
    output logic                  done
);
    logic [DELAY_BITS-1:0] count_q, count_d;
    logic [DELAY_BITS:0]   count_inc;

    // Extra bit and >= keep the compare safe when delay drops below the count.
    assign count_inc = {1'b0, count_q} + (DELAY_BITS+1)'(1);
    assign done      = (delay == '0) || (count_inc >= {1'b0, delay});

    always_comb begin
        count_d = count_q;
        if (clear)      count_d = '0;
        else if (!done) count_d = count_inc[DELAY_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/sink.sv
// Consumer end of the valid_ready bus: programmable back-pressure plus an
// incrementing-sequence checker with beat/error/last-data status.
import vr_pkg::*;

module sink #(
    parameter int DATA_WIDTH = 8,
    parameter int DELAY_BITS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DELAY_BITS-1:0] delay,
    valid_ready.Slave             vrBus,
    output logic [CNT_WIDTH-1:0]  rx_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  seq_error,
    output logic [DATA_WIDTH-1:0] last_data
);
    sink_state_t           state_q, state_d;
    logic                  ready_q, ready_d;
    logic [CNT_WIDTH-1:0]  rx_q, rx_d, err_q, err_d;
    logic                  seq_q, seq_d;
    logic [DATA_WIDTH-1:0] last_q, last_d, exp_q, exp_d;
    logic                  hs, clear, done;

    assign hs    = vrBus.valid && ready_q;
    assign clear = (state_q == READY) && hs && (delay != '0);

    vr_delay_counter #(.DELAY_BITS(DELAY_BITS)) u_dly (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .delay (delay),
        .done  (done)
    );

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        case (state_q)
            WAIT_DELAY: if (done) begin
                ready_d = 1'b1;
                state_d = READY;
            end
            READY: if (clear) begin
                ready_d = 1'b0;
                state_d = WAIT_DELAY;
            end
            default: begin
                ready_d = 1'b0;
                state_d = WAIT_DELAY;
            end
        endcase
    end

    // A mismatch resyncs expected to the received value, so a glitch counts once.
    always_comb begin
        rx_d   = rx_q;
        err_d  = err_q;
        seq_d  = 1'b0;
        last_d = last_q;
        exp_d  = exp_q;
        if (hs) begin
            rx_d   = rx_q + CNT_WIDTH'(1);
            last_d = vrBus.data;
            exp_d  = vrBus.data + DATA_WIDTH'(1);
            if (vrBus.data != exp_q) begin
                seq_d = 1'b1;
                if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_DELAY;
            ready_q <= 1'b0;
            rx_q    <= '0;
            err_q   <= '0;
            seq_q   <= 1'b0;
            last_q  <= '0;
            exp_q   <= DATA_WIDTH'(SEQ_START);
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            seq_q   <= seq_d;
            last_q  <= last_d;
            exp_q   <= exp_d;
        end
    end

    assign vrBus.ready = ready_q;
    assign rx_count    = rx_q;
    assign err_count   = err_q;
    assign seq_error   = seq_q;
    assign last_data   = last_q;
endmodule

// File: tb/tb_sink.sv
// Directed bench for sink: back-pressure timing, sequence checking, reset.
module tb_sink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  delay = 3'd0;
    logic [15:0] rx_count, err_count;
    logic        seq_error;
    logic [7:0]  last_data;
    int checks = 0;
    int errors = 0;

    valid_ready #(.DATA_WIDTH(8)) bus ();

    sink #(.DATA_WIDTH(8), .DELAY_BITS(3), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .delay     (delay),
        .vrBus     (bus.Slave),
        .rx_count  (rx_count),
        .err_count (err_count),
        .seq_error (seq_error),
        .last_data (last_data)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [2:0] d);
        bus.valid = 1'b0;
        bus.data  = 8'd0;
        delay     = d;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Presents one beat and returns the number of edges until it is accepted.
    task automatic send(input logic [7:0] v, output int cyc);
        logic hs;
        bus.data  = v;
        bus.valid = 1'b1;
        cyc = 0;
        do begin
            hs = bus.ready;
            @(posedge clk); #1;
            cyc++;
        end while (!hs && cyc < 50);
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL send_timeout beat %0d not accepted after %0d cycles", v, cyc);
        end
    endtask

    task automatic test_reset();
        bus.valid = 1'b1;
        bus.data  = 8'd1;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({bus.ready, rx_count, err_count, seq_error, last_data} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b rx=%0d err=%0d seq=%b last=%0d required all 0",
                     bus.ready, rx_count, err_count, seq_error, last_data);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b0 || rx_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold got ready=%b rx=%0d required 0 0", bus.ready, rx_count);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset(3'd0);
        for (int v = 1; v <= 8; v++) begin
            send(8'(v), cyc);
            checks++;
            if ((v > 1 && cyc !== 1) || bus.ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_rate beat %0d got cycles=%0d ready=%b required 1 1", v, cyc, bus.ready);
            end
        end
        bus.valid = 1'b0;
        checks++;
        if (rx_count !== 16'd8 || err_count !== 16'd0 || last_data !== 8'd8) begin
            errors++;
            $display("FAIL b2b_status got rx=%0d err=%0d last=%0d required 8 0 8", rx_count, err_count, last_data);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset(3'd3);
        for (int v = 1; v <= 3; v++) begin
            send(8'(v), cyc);
            checks++;
            if (cyc !== 4 || bus.ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_period beat %0d got cycles=%0d ready=%b required 4 0", v, cyc, bus.ready);
            end
        end
        bus.valid = 1'b0;
        checks++;
        if (rx_count !== 16'd3 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL bp_status got rx=%0d err=%0d required 3 0", rx_count, err_count);
        end
    endtask

    task automatic test_seq_error();
        int cyc;
        logic [7:0] vals [4] = '{8'd1, 8'd2, 8'd5, 8'd6};
        logic       exp_e [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(3'd0);
        for (int i = 0; i < 4; i++) begin
            send(vals[i], cyc);
            checks++;
            if (seq_error !== exp_e[i]) begin
                errors++;
                $display("FAIL seq_pulse beat %0d got %b required %b", vals[i], seq_error, exp_e[i]);
            end
        end
        bus.valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (seq_error !== 1'b0 || err_count !== 16'd1 || last_data !== 8'd6 || rx_count !== 16'd4) begin
            errors++;
            $display("FAIL seq_status got seq=%b err=%0d last=%0d rx=%0d required 0 1 6 4",
                     seq_error, err_count, last_data, rx_count);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [7:0] vals [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
        do_reset(3'd0);
        for (int v = 1; v <= 253; v++) send(8'(v), cyc);
        for (int i = 0; i < 4; i++) begin
            send(vals[i], cyc);
            checks++;
            if (seq_error !== 1'b0) begin
                errors++;
                $display("FAIL wrap_seq beat %0d got seq_error=%b required 0", vals[i], seq_error);
            end
        end
        bus.valid = 1'b0;
        checks++;
        if (rx_count !== 16'd257 || err_count !== 16'd0 || last_data !== 8'd1) begin
            errors++;
            $display("FAIL wrap_status got rx=%0d err=%0d last=%0d required 257 0 1", rx_count, err_count, last_data);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset(3'd5);
        send(8'd1, cyc);
        bus.data  = 8'd2;
        bus.valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, rx_count, err_count, seq_error, last_data} !== 42'd0) begin
            errors++;
            $display("FAIL midreset_outputs got ready=%b rx=%0d err=%0d seq=%b last=%0d required all 0",
                     bus.ready, rx_count, err_count, seq_error, last_data);
        end
        @(posedge clk); #1;
        checks++;
        if (rx_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_drop got rx=%0d required 0", rx_count);
        end
        rst_n = 1'b1;
        send(8'd1, cyc);
        bus.valid = 1'b0;
        checks++;
        if (seq_error !== 1'b0 || rx_count !== 16'd1 || err_count !== 16'd0 || last_data !== 8'd1) begin
            errors++;
            $display("FAIL midreset_first got seq=%b rx=%0d err=%0d last=%0d required 0 1 0 1",
                     seq_error, rx_count, err_count, last_data);
        end
    endtask

    task automatic test_delay_change();
        int cyc;
        do_reset(3'd6);
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL dchg_wait got ready=%b required 0", bus.ready);
        end
        delay = 3'd1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL dchg_rise got ready=%b required 1", bus.ready);
        end
        send(8'd1, cyc);
        checks++;
        if (cyc !== 1 || seq_error !== 1'b0) begin
            errors++;
            $display("FAIL dchg_beat1 got cycles=%0d seq=%b required 1 0", cyc, seq_error);
        end
        send(8'd2, cyc);
        bus.valid = 1'b0;
        checks++;
        if (cyc !== 2 || rx_count !== 16'd2 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL dchg_beat2 got cycles=%0d rx=%0d err=%0d required 2 2 0", cyc, rx_count, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_seq_error();
        test_wrap();
        test_reset_mid();
        test_delay_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
